// File: rtl/bsg_cas_sort_sequencer_pkg.sv
// Shared types and helpers for the odd-even transposition sort sequencer.
// Imported by the sequencer top.
package bsg_cas_sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Even passes cover pairs (0,1),(2,3)..; odd passes start at element 1.
  function automatic int pairs_in_pass(input int els, input logic parity);
    return parity ? (els - 1) / 2 : els / 2;
  endfunction

endpackage

// File: rtl/bsg_cas_sort_sequencer_if.sv
// Batch-in (valid/ready) and sorted-batch-out (valid/yumi) bundle for the sort sequencer.
// Signal directions are named from the sequencer's point of view.
interface bsg_cas_sort_sequencer_if #(
  parameter int width_p = 128,
  parameter int els_p   = 8
);
  localparam int SW = $clog2(els_p * (els_p - 1) / 2 + 1);

  logic                       v_i;
  logic [els_p*width_p-1:0]   data_i;
  logic                       ready_o;
  logic                       v_o;
  logic [els_p*width_p-1:0]   data_o;
  logic [SW-1:0]              swaps_o;
  logic                       yumi_i;

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o, swaps_o
  );

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o, swaps_o
  );
endinterface

// File: rtl/bsg_cas_sort_sequencer_cas.sv
// Combinational compare-and-swap of two packed elements; low half leaves holding the smaller.
// Zero latency, no flow control.
module bsg_compare_and_swap #(
  parameter int width_p = 16
) (
  input  logic [2*width_p-1:0] data_i,
  input  logic                 swap_on_equal_i,
  output logic [2*width_p-1:0] data_o,
  output logic                 swapped_o
);

  logic [width_p-1:0] lo;
  logic [width_p-1:0] hi;

  always_comb begin
    lo        = data_i[width_p-1:0];
    hi        = data_i[2*width_p-1:width_p];
    swapped_o = (lo > hi) || (swap_on_equal_i && (lo == hi));
    data_o    = swapped_o ? {lo, hi} : data_i;
  end

endmodule

// File: rtl/bsg_cas_sort_sequencer.sv
// Odd-even transposition sort on one shared compare-and-swap, one compare per cycle.
// Accepts a batch only when IDLE; holds the sorted result in DONE until yumi_i.
module bsg_cas_sort_sequencer
  import bsg_cas_sort_pkg::*;
#(
  parameter int width_p = 128,
  parameter int els_p   = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  bsg_cas_sort_sequencer_if.slave   bus
);

  localparam int PW = $clog2(els_p);
  localparam int SW = $clog2(els_p * (els_p - 1) / 2 + 1);

  if (els_p < 3 || els_p > 64) begin : g_els_range
    $error("bsg_cas_sort_sequencer: els_p must be within 3..64");
  end

  state_e              state_q, state_d;
  logic [width_p-1:0]  elem_q [els_p];
  logic [width_p-1:0]  elem_d [els_p];
  logic [PW-1:0]       pass_q, pass_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic [1:0]          clean_run_q, clean_run_d;
  logic                dirty_q, dirty_d;
  logic [SW-1:0]       swaps_q, swaps_d;

  logic [PW-1:0]       j_lo, j_hi;
  logic [2*width_p-1:0] cas_in, cas_out;
  logic                swapped;
  logic                last_pair;
  logic [1:0]          clean_run_inc;

  bsg_compare_and_swap #(.width_p(width_p)) cas (
    .data_i          (cas_in),
    .swap_on_equal_i (1'b0),
    .data_o          (cas_out),
    .swapped_o       (swapped)
  );

  always_comb begin
    // Pair index j = 2*idx + (pass parity); never exceeds els_p-2.
    j_lo          = {idx_q[PW-2:0], pass_q[0]};
    j_hi          = j_lo + PW'(1);
    cas_in        = {elem_q[j_hi], elem_q[j_lo]};
    last_pair     = (idx_q == PW'(pairs_in_pass(els_p, pass_q[0]) - 1));
    clean_run_inc = (dirty_q || swapped) ? 2'd0 : clean_run_q + 2'd1;

    state_d     = state_q;
    elem_d      = elem_q;
    pass_d      = pass_q;
    idx_d       = idx_q;
    clean_run_d = clean_run_q;
    dirty_d     = dirty_q;
    swaps_d     = swaps_q;

    unique case (state_q)
      IDLE: begin
        if (bus.v_i) begin
          state_d = SORT;
          for (int k = 0; k < els_p; k++) begin
            elem_d[k] = bus.data_i[k*width_p +: width_p];
          end
          pass_d      = '0;
          idx_d       = '0;
          clean_run_d = '0;
          dirty_d     = 1'b0;
          swaps_d     = '0;
        end
      end
      SORT: begin
        if (swapped) begin
          swaps_d = swaps_q + SW'(1);
          for (int k = 0; k < els_p; k++) begin
            if (PW'(k) == j_lo) elem_d[k] = cas_out[width_p-1:0];
            if (PW'(k) == j_hi) elem_d[k] = cas_out[2*width_p-1:width_p];
          end
        end
        if (last_pair) begin
          clean_run_d = clean_run_inc;
          dirty_d     = 1'b0;
          idx_d       = '0;
          // Two clean passes in a row, or the final pass of the worst case.
          if (clean_run_inc == 2'd2 || pass_q == PW'(els_p - 1)) begin
            state_d = DONE;
          end else begin
            pass_d = pass_q + PW'(1);
          end
        end else begin
          idx_d   = idx_q + PW'(1);
          dirty_d = dirty_q | swapped;
        end
      end
      DONE: begin
        if (bus.yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      pass_q      <= '0;
      idx_q       <= '0;
      clean_run_q <= '0;
      dirty_q     <= 1'b0;
      swaps_q     <= '0;
      for (int k = 0; k < els_p; k++) elem_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      idx_q       <= idx_d;
      clean_run_q <= clean_run_d;
      dirty_q     <= dirty_d;
      swaps_q     <= swaps_d;
      elem_q      <= elem_d;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.v_o     = (state_q == DONE);
  assign bus.swaps_o = swaps_q;

  for (genvar g = 0; g < els_p; g++) begin : g_data_o
    assign bus.data_o[g*width_p +: width_p] = elem_q[g];
  end

endmodule

// File: tb/tb_bsg_cas_sort_sequencer.sv
// Randomized bench for the CAS sort sequencer: small 4x8 instance for directed corners,
// 8x128 instance for random back-to-back traffic against an array-sort scoreboard.
module tb_bsg_cas_sort_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  bsg_cas_sort_sequencer_if #(.width_p(8),   .els_p(4)) s4 ();
  bsg_cas_sort_sequencer_if #(.width_p(128), .els_p(8)) s8 ();

  bsg_cas_sort_sequencer #(.width_p(8), .els_p(4)) dut4 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (s4.slave)
  );

  bsg_cas_sort_sequencer #(.width_p(128), .els_p(8)) dut8 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (s8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference: plain sort of the element list; each adjacent strict swap removes
  // exactly one inversion, so the swap count equals the inversion count.
  task automatic ref_sort(input logic [1023:0] din, input int n, input int w,
                          output logic [1023:0] dout, output int inv);
    logic [127:0] a [8];
    logic [127:0] t;
    inv  = 0;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      a[i] = '0;
      for (int b = 0; b < w; b++) a[i][b] = din[i*w + b];
    end
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        if (a[i] > a[j]) inv++;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < n; i++)
      for (int b = 0; b < w; b++) dout[i*w + b] = a[i][b];
  endtask

  // Called #1 after a clock edge with dut4 idle; returns SORT cycles observed.
  task automatic run4(input logic [31:0] d, output int cyc);
    s4.v_i    = 1'b1;
    s4.data_i = d;
    @(posedge clk); #1;
    s4.v_i = 1'b0;
    cyc = 0;
    while (!s4.v_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!s4.v_o) chk("timeout4", 0, 1);
  endtask

  task automatic release4();
    s4.yumi_i = 1'b1;
    @(posedge clk); #1;
    s4.yumi_i = 1'b0;
  endtask

  task automatic sort4_vs_model(input string tag, input logic [31:0] d);
    logic [1023:0] exp_d;
    int inv, cyc;
    ref_sort({992'b0, d}, 4, 8, exp_d, inv);
    chk({tag, "_rdy"}, s4.ready_o, 1);
    run4(d, cyc);
    chk({tag, "_data"}, s4.data_o, exp_d[31:0]);
    chk({tag, "_swaps"}, s4.swaps_o, inv);
    chk({tag, "_cyc_le6"}, cyc <= 6, 1);
    release4();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [1023:0] exp_d;
    logic [1023:0] din;
    logic [31:0]   held_d;
    logic [2:0]    held_s;
    logic [127:0]  v;
    int inv, cyc;

    rst_n     = 1'b0;
    s4.v_i    = 1'b0; s4.data_i = '0; s4.yumi_i = 1'b0;
    s8.v_i    = 1'b0; s8.data_i = '0; s8.yumi_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_ready", s4.ready_o, 1);
    chk("rst_v", s4.v_o, 0);
    chk("rst_swaps", s4.swaps_o, 0);
    chk("rst_data", s4.data_o, 0);
    chk("rst_ready8", s8.ready_o, 1);

    // yumi while nothing is valid must not disturb the idle block
    s4.yumi_i = 1'b1;
    @(posedge clk); #1;
    s4.yumi_i = 1'b0;
    chk("idle_yumi_ready", s4.ready_o, 1);
    chk("idle_yumi_v", s4.v_o, 0);

    // already sorted: one even + one odd clean pass
    run4(pack4(1, 2, 3, 4), cyc);
    chk("sorted_cyc", cyc, 3);
    chk("sorted_data", s4.data_o, pack4(1, 2, 3, 4));
    chk("sorted_swaps", s4.swaps_o, 0);
    release4();

    // reversed: worst case, all four passes
    run4(pack4(4, 3, 2, 1), cyc);
    chk("rev_cyc", cyc, 6);
    chk("rev_data", s4.data_o, pack4(1, 2, 3, 4));
    chk("rev_swaps", s4.swaps_o, 6);
    release4();

    // duplicates: equal pairs never swap
    run4(pack4(5, 5, 2, 5), cyc);
    chk("dup_data", s4.data_o, pack4(2, 5, 5, 5));
    chk("dup_swaps", s4.swaps_o, 2);
    release4();

    // backpressure in DONE
    ref_sort({992'b0, pack4(9, 7, 8, 1)}, 4, 8, exp_d, inv);
    run4(pack4(9, 7, 8, 1), cyc);
    held_d = s4.data_o;
    held_s = s4.swaps_o;
    chk("bp_data0", held_d, exp_d[31:0]);
    chk("bp_swaps0", held_s, inv);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_v", s4.v_o, 1);
      chk("bp_ready", s4.ready_o, 0);
      chk("bp_data", s4.data_o, exp_d[31:0]);
      chk("bp_swaps", s4.swaps_o, inv);
    end
    release4();
    chk("bp_rel_ready", s4.ready_o, 1);
    chk("bp_rel_v", s4.v_o, 0);

    // reset mid-sort: one swap already counted, reset must clear it immediately
    s4.v_i    = 1'b1;
    s4.data_i = pack4(4, 3, 2, 1);
    @(posedge clk); #1;
    s4.v_i = 1'b0;
    @(posedge clk); #1;
    chk("midsort_busy", s4.ready_o, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_v", s4.v_o, 0);
    chk("mrst_ready", s4.ready_o, 1);
    chk("mrst_swaps", s4.swaps_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sort4_vs_model("after_rst", pack4(3, 1, 4, 2));

    for (int t = 0; t < 20; t++) begin
      sort4_vs_model("rnd4", $urandom());
    end

    // 8 x 128-bit random traffic, next batch offered right after each yumi
    for (int b = 0; b < 1000; b++) begin
      v = rnd128();
      din = '0;
      for (int e = 0; e < 8; e++) begin
        case (b % 6)
          0: din[e*128 +: 128] = v;
          1: din[e*128 +: 128] = {128{1'b1}};
          2: case ($urandom_range(0, 2))
               0:       din[e*128 +: 128] = '0;
               1:       din[e*128 +: 128] = {128{1'b1}};
               default: din[e*128 +: 128] = 128'($urandom_range(0, 3));
             endcase
          3: din[e*128 +: 128] = 128'($urandom_range(0, 3));
          default: din[e*128 +: 128] = rnd128();
        endcase
      end
      ref_sort(din, 8, 128, exp_d, inv);
      chk("b8_ready", s8.ready_o, 1);
      s8.v_i    = 1'b1;
      s8.data_i = din;
      @(posedge clk); #1;
      s8.v_i = 1'b0;
      cyc = 0;
      while (!s8.v_o && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (!s8.v_o) begin
        chk("timeout8", 0, 1);
      end else begin
        chk("b8_data", s8.data_o, exp_d);
        chk("b8_swaps", s8.swaps_o, inv);
        chk("b8_cyc_le28", cyc <= 28, 1);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      s8.yumi_i = 1'b1;
      @(posedge clk); #1;
      s8.yumi_i = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
